except_ctrl: RTL
================

EXCEPT_CTRL -- requirements
Module: except_ctrl

Interface
REQ-001 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-002 SHALL have ports, as name  direction  width  meaning:
  clk  in  1  clock
  rst  in  1  sync active-high reset
  valid_i  in  1  MEM-stage instruction valid
  pc_i  in  32  MEM-stage instruction address
  in_delayslot_i  in  1  MEM instruction is in a delay slot
  exc_flags_i  in  8  [0] fetch AdEL, [1] RI, [2] Ov, [3] syscall, [4] break, [5] load AdEL, [6] AdES, [7] eret
  bad_addr_i  in  32  data address of faulting load/store
  status_i  in  32  CP0 Status
  cause_i  in  32  CP0 Cause
  epc_i  in  32  CP0 EPC
  mem_busy_i  in  1  outstanding data-bus transaction
  excepttype_o  out  32  exception code to CP0
  cur_pc_o  out  32  faulting PC to CP0
  delayslot_o  out  1  delay-slot flag to CP0
  badvaddr_o  out  32  bad address to CP0
  stall_o  out  1  freeze pipeline
  flush_o  out  1  flush all stages
  redirect_o  out  1  newpc_o valid, one-cycle pulse
  newpc_o  out  32  redirect target
REQ-003 SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning exception entry address.

Function
REQ-004 SHALL raise interrupt-pending when status_i[0]=1, status_i[1]=0 and (cause_i[15:8] & status_i[15:8]) != 0.
REQ-005 SHALL detect an event in IDLE only when valid_i=1 and (interrupt-pending or any exc_flags_i bit is set).
REQ-006 SHALL prioritise events, highest first: interrupt 0x01, fetch AdEL 0x04, RI 0x0a, Ov 0x0c, syscall 0x08, break 0x09, load AdEL 0x04, AdES 0x05, eret 0x0e.
REQ-007 SHALL, in the detection cycle, latch code, pc_i, in_delayslot_i, and badvaddr (pc_i for fetch AdEL; bad_addr_i for load AdEL/AdES; else 0).
REQ-008 SHALL implement FSM states IDLE, WAIT, COMMIT, REDIRECT.
REQ-009 SHALL transition IDLE->COMMIT on detection with mem_busy_i=0, and IDLE->WAIT on detection with mem_busy_i=1.
REQ-010 SHALL stay in WAIT while mem_busy_i=1 and go to COMMIT on the first cycle with mem_busy_i=0.
REQ-011 SHALL go COMMIT->REDIRECT after exactly one cycle, and REDIRECT->IDLE after exactly one cycle.
REQ-012 SHALL assert stall_o combinationally in the detection cycle and throughout WAIT, COMMIT and REDIRECT.
REQ-013 SHALL, in COMMIT only, drive excepttype_o, cur_pc_o, delayslot_o and badvaddr_o from the latches and assert flush_o; otherwise excepttype_o=0 and flush_o=0.
REQ-014 SHALL, in REDIRECT only, assert redirect_o, with newpc_o=epc_i for eret and EXC_VECTOR otherwise; otherwise newpc_o=0.
REQ-015 SHALL ignore valid_i, exc_flags_i and interrupts outside IDLE, with no queuing.
REQ-016 SHALL treat multiple simultaneous flag bits by REQ-006 priority only, and SHALL NOT report a lower-priority event later.
REQ-017 SHALL complete any started sequence even if interrupt-pending deasserts.
REQ-018 SHALL give minimum detection-to-redirect latency of 2 cycles (detect, COMMIT, REDIRECT), plus one cycle per WAIT cycle.

Reset
REQ-019 SHALL, on rst, enter IDLE within one clock and clear all latches.
REQ-020 SHALL hold every output at 0 while rst=1, including during a sequence in progress.
REQ-021 SHALL NOT emit flush_o or redirect_o for a sequence aborted by reset.

Verification
REQ-022 syscall: valid_i=1, pc_i=0xBFC00100, flags=0x08, mem_busy_i=0 -> next cycle excepttype_o=0x08, cur_pc_o=0xBFC00100, flush_o=1; the cycle after, redirect_o=1 and newpc_o=0xBFC00380.
REQ-023 interrupt vs. RI: status=0x0000_0401, cause[10]=1, flags=0x02 -> excepttype_o=0x01 only, and no later 0x0a.
REQ-024 AdES in delay slot: flags=0x40, bad_addr_i=0x80000003, in_delayslot_i=1, mem_busy_i=1 for 3 cycles -> stall_o=1 throughout; COMMIT 4 cycles after detection with badvaddr_o=0x80000003 and delayslot_o=1.
REQ-025 eret: flags=0x80, epc_i=0xBFC00424 -> excepttype_o=0x0e, then newpc_o=0xBFC00424 with redirect_o=1.
REQ-026 masked interrupt: status[1]=1 with a pending IRQ -> no detection, stall_o=0.
REQ-027 reset in WAIT: rst=1 for one cycle -> IDLE with outputs 0, and no flush_o or redirect_o afterwards.

Source files
------------

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: prioritises interrupts and exceptions, holds the
// pipeline while the data bus drains, then reports to CP0 and redirects the PC.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] bad_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        mem_busy_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] cur_pc_o,
    output logic        delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] newpc_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [7:0] CODE_INT  = 8'h01;
    localparam logic [7:0] CODE_ADEL = 8'h04;
    localparam logic [7:0] CODE_ADES = 8'h05;
    localparam logic [7:0] CODE_SYS  = 8'h08;
    localparam logic [7:0] CODE_BP   = 8'h09;
    localparam logic [7:0] CODE_RI   = 8'h0a;
    localparam logic [7:0] CODE_OV   = 8'h0c;
    localparam logic [7:0] CODE_ERET = 8'h0e;

    state_t      state;
    state_t      state_next;

    logic        irq_pending;
    logic        event_hit;
    logic [7:0]  sel_code;
    logic [31:0] sel_badvaddr;

    logic [7:0]  code_q;
    logic [31:0] pc_q;
    logic        delayslot_q;
    logic [31:0] badvaddr_q;
    logic        eret_q;

    // Interrupts are taken only with IE set, EXL clear, and an unmasked line pending.
    assign irq_pending = status_i[0] && !status_i[1] &&
                         ((cause_i[15:8] & status_i[15:8]) != 8'h00);

    assign event_hit = (state == IDLE) && valid_i &&
                       (irq_pending || (exc_flags_i != 8'h00));

    // Fixed priority chain; only the winning cause is ever recorded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel_code     = 8'h00;
        sel_badvaddr = 32'h0;
        if (irq_pending) begin
            sel_code = CODE_INT;
        end else if (exc_flags_i[0]) begin
            sel_code     = CODE_ADEL;
            sel_badvaddr = pc_i;
        end else if (exc_flags_i[1]) begin
            sel_code = CODE_RI;
        end else if (exc_flags_i[2]) begin
            sel_code = CODE_OV;
        end else if (exc_flags_i[3]) begin
            sel_code = CODE_SYS;
        end else if (exc_flags_i[4]) begin
            sel_code = CODE_BP;
        end else if (exc_flags_i[5]) begin
            sel_code     = CODE_ADEL;
            sel_badvaddr = bad_addr_i;
        end else if (exc_flags_i[6]) begin
            sel_code     = CODE_ADES;
            sel_badvaddr = bad_addr_i;
        end else if (exc_flags_i[7]) begin
            sel_code = CODE_ERET;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (event_hit) begin
                    state_next = mem_busy_i ? WAIT : COMMIT;
                end
            end
            WAIT: begin
                if (!mem_busy_i) begin
                    state_next = COMMIT;
                end
            end
            COMMIT:   state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Event record, captured only in the detection cycle.
    always_ff @(posedge clk) begin
        // NOTE: these registers are reset explicitly so an aborted sequence leaves nothing behind.
        if (rst) begin
            code_q      <= 8'h00;
            pc_q        <= 32'h0;
            delayslot_q <= 1'b0;
            badvaddr_q  <= 32'h0;
            eret_q      <= 1'b0;
        end else if (event_hit) begin
            code_q      <= sel_code;
            pc_q        <= pc_i;
            delayslot_q <= in_delayslot_i;
            badvaddr_q  <= sel_badvaddr;
            eret_q      <= (sel_code == CODE_ERET);
        end
    end

    // Output logic; everything is forced low while reset is held.
    always_comb begin
        excepttype_o = 32'h0;
        cur_pc_o     = 32'h0;
        delayslot_o  = 1'b0;
        badvaddr_o   = 32'h0;
        stall_o      = 1'b0;
        flush_o      = 1'b0;
        redirect_o   = 1'b0;
        newpc_o      = 32'h0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    stall_o = event_hit;
                end
                WAIT: begin
                    stall_o = 1'b1;
                end
                COMMIT: begin
                    stall_o      = 1'b1;
                    flush_o      = 1'b1;
                    excepttype_o = {24'h0, code_q};
                    cur_pc_o     = pc_q;
                    delayslot_o  = delayslot_q;
                    badvaddr_o   = badvaddr_q;
                end
                REDIRECT: begin
                    stall_o    = 1'b1;
                    redirect_o = 1'b1;
                    newpc_o    = eret_q ? epc_i : EXC_VECTOR;
                end
                default: ;
            endcase
        end
    end

endmodule
